// File: rtl/io_write_port_fifo.sv
// Peripheral end of a CPU I/O write port: buffers io_out words and returns a registered full flag.
// Define IO_WRITE_PORT_OVERFLOW_EN to build the sticky dropped-write detector; otherwise overflow is tied low.
module io_write_port_fifo #(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int EF_SLACK   = 2,
  parameter     RAMSTYLE   = "MLAB"
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_wren,
  input  logic [WORD_WIDTH-1:0] io_out,
  output logic                  io_out_EF,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  // (DEPTH - count) <= EF_SLACK rewritten as count >= DEPTH - EF_SLACK to stay unsigned.
  localparam logic [ADDR_WIDTH:0]   EF_THRESH = (ADDR_WIDTH + 1)'(DEPTH - EF_SLACK);

  (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  io_out_ef_q, io_out_ef_d;
  logic                  wr_accept;
  logic                  rd_fire;

  always_comb begin
    // Acceptance looks only at start-of-cycle count: a full FIFO rejects even when a read frees a slot.
    wr_accept = io_wren && (count_q < CNT_DEPTH);
    rd_fire   = (count_q != '0) && out_ready;

    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    case ({wr_accept, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    io_out_ef_d = (count_d >= EF_THRESH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      io_out_ef_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      io_out_ef_q <= io_out_ef_d;
    end
  end

  // Storage is never reset; stale words are hidden behind count.
  always_ff @(posedge clock) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr_q] <= io_out;
    end
  end

`ifdef IO_WRITE_PORT_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (io_wren && (count_q == CNT_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr_q];
  assign count     = count_q;
  assign io_out_EF = io_out_ef_q;

endmodule

// File: tb/tb_io_write_port_fifo.sv
// Directed bench for io_write_port_fifo (DEPTH=8, EF_SLACK=2, WORD_WIDTH=36).
// Expected overflow behaviour follows IO_WRITE_PORT_OVERFLOW_EN as seen by this compile.
module tb_io_write_port_fifo;

  localparam int WW = 36;

`ifdef IO_WRITE_PORT_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          io_wren;
  logic [WW-1:0] io_out;
  logic          io_out_EF;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [3:0]    count;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  io_write_port_fifo #(
    .WORD_WIDTH(WW), .DEPTH(8), .ADDR_WIDTH(3), .EF_SLACK(2), .RAMSTYLE("MLAB")
  ) dut (
    .clock(clock), .reset(reset), .io_wren(io_wren), .io_out(io_out),
    .io_out_EF(io_out_EF), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; io_wren = 1'b0; out_ready = 1'b0; io_out = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [WW-1:0] d);
    io_wren = 1'b1; io_out = d;
    step();
    io_wren = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; io_wren = 1'b1; out_ready = 1'b1; io_out = 36'hFFF;
    step(); step();
    reset = 1'b0; io_wren = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (io_out_EF !== 1'b0) begin n_bad++; $display("FAIL reset_ef: got %b want 0", io_out_EF); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    $display("reset: count=%0d valid=%b ef=%b ovf=%b", count, out_valid, io_out_EF, overflow);
  endtask

  task automatic test_single();
    push(36'h123456789);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 36'h123456789) begin n_bad++; $display("FAIL single_data: got %h want 123456789", out_data); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", count); end
    $display("single write: valid=%b data=%h count=%0d", out_valid, out_data, count);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_rd_valid: got %b want 0", out_valid); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL single_rd_count: got %0d want 0", count); end
    $display("single read: valid=%b count=%0d", out_valid, count);
  endtask

  task automatic test_full_flag();
    for (int k = 1; k <= 8; k++) begin
      push(36'h100 + 36'(k));
      n_cmp++; if (count !== 4'(k)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, count, k); end
      n_cmp++; if (io_out_EF !== (k >= 6)) begin n_bad++; $display("FAIL fill_ef[%0d]: got %b want %b", k, io_out_EF, (k >= 6)); end
      $display("write %0d: count=%0d ef=%b", k, count, io_out_EF);
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    push(36'hBAD);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", count); end
    n_cmp++; if (out_data !== 36'h101) begin n_bad++; $display("FAIL ovf_head: got %h want 101", out_data); end
    n_cmp++; if (overflow !== OVF_EN) begin n_bad++; $display("FAIL ovf_flag: got %b want %b", overflow, OVF_EN); end
    $display("dropped write: count=%0d head=%h ovf=%b", count, out_data, overflow);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_data !== 36'h101 + 36'(i)) begin n_bad++; $display("FAIL drain[%0d]: got %h want %h", i, out_data, 36'h101 + 36'(i)); end
      $display("drain %0d: data=%h", i, out_data);
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL drain_count: got %0d want 0", count); end
    n_cmp++; if (io_out_EF !== 1'b0) begin n_bad++; $display("FAIL drain_ef: got %b want 0", io_out_EF); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) push(36'h200 + 36'(i));
    io_wren = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      io_out = 36'h204 + 36'(j);
      n_cmp++; if (out_data !== 36'h200 + 36'(j)) begin n_bad++; $display("FAIL simul_data[%0d]: got %h want %h", j, out_data, 36'h200 + 36'(j)); end
      step();
      n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL simul_count[%0d]: got %0d want 4", j, count); end
      $display("simul %0d: data out=%h count=%0d", j, 36'h200 + 36'(j), count);
    end
    io_wren = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(36'h218 + 36'(i));
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL simul_fill: got %0d want 8", count); end
    io_wren = 1'b1; out_ready = 1'b1; io_out = 36'hFFF;
    step();
    io_wren = 1'b0;
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL full_rw_count: got %0d want 7", count); end
    n_cmp++; if (overflow !== OVF_EN) begin n_bad++; $display("FAIL full_rw_ovf: got %b want %b", overflow, OVF_EN); end
    $display("full read+write: count=%0d ovf=%b", count, overflow);
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (out_data !== 36'h215 + 36'(i)) begin n_bad++; $display("FAIL full_rw_drain[%0d]: got %h want %h", i, out_data, 36'h215 + 36'(i)); end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_rw_empty: got %b want 0", out_valid); end
    $display("full read+write drain: count=%0d", count);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) push(36'h300 + 36'(i));
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 5", count); end
    n_cmp++; if (io_out_EF !== 1'b0) begin n_bad++; $display("FAIL mid_pre_ef: got %b want 0", io_out_EF); end
    reset = 1'b1; io_wren = 1'b1; io_out = 36'h3AA;
    step();
    reset = 1'b0; io_wren = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (io_out_EF !== 1'b0) begin n_bad++; $display("FAIL mid_ef: got %b want 0", io_out_EF); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    $display("mid reset: count=%0d valid=%b ef=%b ovf=%b", count, out_valid, io_out_EF, overflow);
    push(36'h3BB);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL post_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 36'h3BB) begin n_bad++; $display("FAIL post_data: got %h want 3bb", out_data); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL post_count: got %0d want 1", count); end
    $display("post reset write: valid=%b data=%h count=%0d", out_valid, out_data, count);
  endtask

  initial begin
    reset = 1'b1; io_wren = 1'b0; out_ready = 1'b0; io_out = '0;
    #1;
    test_reset();
    test_single();
    test_full_flag();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_write_port_fifo.md
IO_WRITE_PORT_FIFO -- requirements
Module: io_write_port_fifo

Interface
REQ-001 Parameters SHALL be, one per line:
- WORD_WIDTH, default 36, width of one I/O word.
- DEPTH, default 8, FIFO capacity in words, any value >= 2.
- ADDR_WIDTH, default 3, pointer width, SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
- EF_SLACK, default 2, free slots reserved for CPU writes already in flight, 0 <= EF_SLACK < DEPTH.
- RAMSTYLE, default "MLAB", storage synthesis attribute.
REQ-002 Ports SHALL be, one per line:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_wren  in  1  CPU write-port strobe.
- io_out  in  WORD_WIDTH  CPU write-port data.
- io_out_EF  out  1  full flag returned to the CPU write port; 1 = CPU must not issue writes.
- out_valid  out  1  a word is available downstream.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WORD_WIDTH  head-of-FIFO word.
- count  out  ADDR_WIDTH+1  words currently stored.
- overflow  out  1  sticky dropped-write error.

Function
REQ-003 The block SHALL be the peripheral end of one CPU I/O write port: it absorbs io_wren/io_out and drives io_out_EF back.
REQ-004 A write SHALL be accepted on a cycle where io_wren=1 and count<DEPTH at the start of the cycle. The word SHALL be stored at wr_ptr.
REQ-005 A read SHALL occur on a cycle where out_valid=1 and out_ready=1. rd_ptr SHALL advance by one.
REQ-006 out_valid SHALL equal (count!=0). out_data SHALL equal mem[rd_ptr]. out_data is don't-care while out_valid=0.
REQ-007 Write-to-output latency SHALL be 1 cycle: a word accepted at edge N into an empty FIFO gives out_valid=1 after edge N.
REQ-008 Each pointer SHALL wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
REQ-009 count SHALL change by +1 on a write only, by -1 on a read only, and by 0 on a simultaneous write and read.
REQ-010 When the FIFO is full and a read occurs in the same cycle, the concurrent write SHALL NOT be accepted. Acceptance uses start-of-cycle count; there is no full pass-through.
REQ-011 When the FIFO is empty, a concurrent io_wren SHALL be accepted and no read SHALL occur.
REQ-012 io_out_EF SHALL be registered, computed from next-state count as (DEPTH - count_next) <= EF_SLACK.
REQ-013 io_wren while count=DEPTH SHALL be dropped. Storage, pointers and count SHALL remain unchanged.
REQ-014 Storage contents SHALL NOT require reset. Only pointers, count, io_out_EF and overflow are reset.

Reset
REQ-015 While reset=1 at a rising edge, the following SHALL be cleared on that edge regardless of io_wren/out_ready: wr_ptr=0, rd_ptr=0, count=0, io_out_EF=0, overflow=0, out_valid=0.
REQ-016 A reset asserted mid-operation SHALL discard all stored words. The first write after reset deassertion SHALL be accepted normally.

Configuration
REQ-017 Macro IO_WRITE_PORT_OVERFLOW_EN SHALL control overflow detection:
- Defined: overflow SHALL be set on the edge after any dropped write per REQ-013, and SHALL hold until reset.
- Undefined: overflow SHALL be tied to 0 and no detection logic built. The port list is identical in both cases.

Verification
Bench parameters for REQ-018 to REQ-022: DEPTH=8, EF_SLACK=2, WORD_WIDTH=36.
REQ-018 Single write -> single read:
- After reset, write 0x123456789 with out_ready=0 -> next cycle out_valid=1, out_data=0x123456789, count=1.
- Then assert out_ready for one cycle -> out_valid=0, count=0.
REQ-019 Full flag:
- Write 6 words, out_ready=0 -> io_out_EF=1 after the 6th write edge (2 free); EF=0 after the 5th.
- 2 further writes -> count=8, none dropped, overflow=0.
REQ-020 Overflow:
- With count=8, pulse io_wren with 0xBAD -> count stays 8, head word unchanged.
- overflow=1 with the macro defined; 0 without it.
- Drain 8 words -> original order preserved, 0xBAD never appears.
REQ-021 Simultaneous events:
- count=4, io_wren=1 and out_ready=1 for 20 cycles -> count holds 4 and words emerge in order across pointer wrap.
- count=8 with both active -> read occurs, write rejected, count=7.
REQ-022 Reset mid-operation:
- count=5, io_out_EF=0, assert reset one cycle with io_wren=1 -> count=0, out_valid=0, io_out_EF=0, overflow=0.
- Next write appears at out_data one cycle later.
